// File: rtl/nibble_bus_ctrl_if.sv
// Handshake and nibble-bus signals between a requester and nibble_bus_ctrl.
// master drives the request fields and bus view; slave is the controller.
interface nibble_bus_ctrl_if;
    logic       req;
    logic [1:0] src;
    logic [1:0] dst;
    logic       wr;
    logic [3:0] bus_in;
    logic [3:0] out_en;
    logic [3:0] load;
    logic [3:0] rd_data;
    logic       busy;
    logic       done;

    modport master (
        output req, src, dst, wr, bus_in,
        input  out_en, load, rd_data, busy, done
    );

    modport slave (
        input  req, src, dst, wr, bus_in,
        output out_en, load, rd_data, busy, done
    );
endinterface

// File: rtl/nibble_bus_ctrl.sv
// Sequences one register-to-register transfer over a shared nibble bus:
// enable source, let the bus settle, strobe destination, hold, then release.
module nibble_bus_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               reset,
    nibble_bus_ctrl_if.slave   bus
);
    // state  | meaning
    // IDLE   | bus released, waiting for req
    // DRIVE  | source enabled, bus settling for SETTLE cycles
    // STROBE | destination load strobe, bus sampled into rd_data
    // HOLD   | source still enabled past the load edge, done pulse
    typedef enum logic [1:0] {IDLE, DRIVE, STROBE, HOLD} state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_settle;
    logic [3:0] w_settle_nxt;
    logic [1:0] r_src;
    logic [1:0] r_dst;
    logic       r_wr;
    logic [3:0] r_rd_data;

    logic [3:0] w_out_en;
    logic [3:0] w_load;
    logic       w_busy;
    logic       w_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_settle  <= 4'd0;
            r_src     <= 2'd0;
            r_dst     <= 2'd0;
            r_wr      <= 1'b0;
            r_rd_data <= 4'h0;
        end else begin
            r_state  <= w_state_nxt;
            r_settle <= w_settle_nxt;
            if (r_state == IDLE && bus.req) begin
                r_src <= bus.src;
                r_dst <= bus.dst;
                r_wr  <= bus.wr;
            end
            if (r_state == STROBE) begin
                r_rd_data <= bus.bus_in;
            end
        end
    end

    // Settle timer is a down-counter loaded on entry to DRIVE; zero is terminal.
    always_comb begin
        w_state_nxt  = r_state;
        w_settle_nxt = r_settle;
        case (r_state)
            IDLE: begin
                if (bus.req) begin
                    w_state_nxt  = DRIVE;
                    w_settle_nxt = SETTLE_INIT;
                end
            end
            DRIVE: begin
                if (r_settle == 4'd0) begin
                    w_state_nxt = STROBE;
                end else begin
                    w_settle_nxt = r_settle - 4'd1;
                end
            end
            STROBE:  w_state_nxt = HOLD;
            HOLD:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_out_en = 4'b1111;
        w_load   = 4'b0000;
        w_done   = 1'b0;
        w_busy   = (r_state != IDLE);
        case (r_state)
            DRIVE: begin
                w_out_en[r_src] = 1'b0;
            end
            STROBE: begin
                w_out_en[r_src] = 1'b0;
                w_load[r_dst]   = r_wr;
            end
            HOLD: begin
                w_out_en[r_src] = 1'b0;
                w_done          = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.out_en  = w_out_en;
    assign bus.load    = w_load;
    assign bus.rd_data = r_rd_data;
    assign bus.busy    = w_busy;
    assign bus.done    = w_done;
endmodule

// File: tb/tb_nibble_bus_ctrl.sv
// Directed bench for nibble_bus_ctrl with SETTLE=1 and SETTLE=3 instances.
module tb_nibble_bus_ctrl;
    logic clk = 1'b0;
    logic rst1;
    logic rst3;
    int   total = 0;
    int   bad   = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    nibble_bus_ctrl_if b1 ();
    nibble_bus_ctrl_if b3 ();

    nibble_bus_ctrl #(.SETTLE(1)) u_dut1 (.clk(clk), .reset(rst1), .bus(b1.slave));
    nibble_bus_ctrl #(.SETTLE(3)) u_dut3 (.clk(clk), .reset(rst3), .bus(b3.slave));

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic bus_violation(input logic [3:0] oe, input logic [3:0] ld);
        return ($countones(~oe) > 1) || ($countones(ld) > 1) || ((|ld) && (&oe));
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("bus_rules_s1", 8'(bus_violation(b1.out_en, b1.load)), 8'd0);
            chk("bus_rules_s3", 8'(bus_violation(b3.out_en, b3.load)), 8'd0);
        end
    end

    initial begin
        int nd;
        b1.req = 1'b0; b1.src = 2'd0; b1.dst = 2'd0; b1.wr = 1'b0; b1.bus_in = 4'h0;
        b3.req = 1'b0; b3.src = 2'd0; b3.dst = 2'd0; b3.wr = 1'b0; b3.bus_in = 4'h0;
        rst1 = 1'b1;
        rst3 = 1'b1;
        step();
        step();
        rst1 = 1'b0;
        rst3 = 1'b0;
        mon_en = 1'b1;
        chk("rst_out_en", 8'(b1.out_en), 8'hF);
        chk("rst_load", 8'(b1.load), 8'h0);
        chk("rst_busy", 8'(b1.busy), 8'h0);
        chk("rst_done", 8'(b1.done), 8'h0);
        chk("rst_rd_data", 8'(b1.rd_data), 8'h0);
        step();
        chk("idle_no_req_busy", 8'(b1.busy), 8'h0);

        // basic write: src=2 -> dst=0
        b1.src = 2'd2; b1.dst = 2'd0; b1.wr = 1'b1; b1.bus_in = 4'hA; b1.req = 1'b1;
        step();
        b1.req = 1'b0;
        chk("t29_c1_out_en", 8'(b1.out_en), 8'b1011);
        chk("t29_c1_load", 8'(b1.load), 8'h0);
        chk("t29_c1_busy", 8'(b1.busy), 8'h1);
        chk("t29_c1_done", 8'(b1.done), 8'h0);
        step();
        chk("t29_c2_out_en", 8'(b1.out_en), 8'b1011);
        chk("t29_c2_load", 8'(b1.load), 8'b0001);
        chk("t29_c2_done", 8'(b1.done), 8'h0);
        step();
        chk("t29_c3_out_en", 8'(b1.out_en), 8'b1011);
        chk("t29_c3_load", 8'(b1.load), 8'h0);
        chk("t29_c3_rd_data", 8'(b1.rd_data), 8'hA);
        chk("t29_c3_done", 8'(b1.done), 8'h1);
        step();
        chk("t29_c4_busy", 8'(b1.busy), 8'h0);
        chk("t29_c4_out_en", 8'(b1.out_en), 8'hF);
        chk("t29_c4_done", 8'(b1.done), 8'h0);

        // read only: src=3, no load at any point
        b1.src = 2'd3; b1.dst = 2'd1; b1.wr = 1'b0; b1.bus_in = 4'h5; b1.req = 1'b1;
        nd = 0;
        for (int c = 1; c <= 4; c++) begin
            step();
            b1.req = 1'b0;
            chk("t30_load", 8'(b1.load), 8'h0);
            nd += int'(b1.done);
            if (c == 1) chk("t30_c1_out_en", 8'(b1.out_en), 8'b0111);
        end
        chk("t30_rd_data", 8'(b1.rd_data), 8'h5);
        chk("t30_done_cnt", 8'(nd), 8'd1);

        // self reload: src==dst=1
        b1.src = 2'd1; b1.dst = 2'd1; b1.wr = 1'b1; b1.bus_in = 4'h7; b1.req = 1'b1;
        step();
        b1.req = 1'b0;
        chk("t34_c1_out_en", 8'(b1.out_en), 8'b1101);
        chk("t34_c1_load", 8'(b1.load), 8'h0);
        step();
        chk("t34_c2_out_en", 8'(b1.out_en), 8'b1101);
        chk("t34_c2_load", 8'(b1.load), 8'b0010);
        step();
        chk("t34_c3_rd_data", 8'(b1.rd_data), 8'h7);
        chk("t34_c3_done", 8'(b1.done), 8'h1);
        step();

        // req held high; src/dst change mid-transfer must be ignored
        b1.src = 2'd0; b1.dst = 2'd3; b1.wr = 1'b1; b1.bus_in = 4'hC; b1.req = 1'b1;
        step();
        b1.src = 2'd2; b1.dst = 2'd1;
        chk("t33_c1_out_en", 8'(b1.out_en), 8'b1110);
        step();
        chk("t33_c2_out_en", 8'(b1.out_en), 8'b1110);
        chk("t33_c2_load", 8'(b1.load), 8'b1000);
        step();
        chk("t33_c3_done", 8'(b1.done), 8'h1);
        chk("t33_c3_rd_data", 8'(b1.rd_data), 8'hC);
        step();
        chk("t33_c4_gap_busy", 8'(b1.busy), 8'h0);
        step();
        chk("t33_c5_busy", 8'(b1.busy), 8'h1);
        chk("t33_c5_out_en", 8'(b1.out_en), 8'b1011);
        step();
        b1.req = 1'b0;
        chk("t33_c6_load", 8'(b1.load), 8'b0010);
        step();
        chk("t33_c7_done", 8'(b1.done), 8'h1);
        step();
        chk("t33_c8_busy", 8'(b1.busy), 8'h0);

        // reset during STROBE
        b1.src = 2'd2; b1.dst = 2'd0; b1.wr = 1'b1; b1.bus_in = 4'h9; b1.req = 1'b1;
        step();
        b1.req = 1'b0;
        step();
        chk("t32_strobe_load", 8'(b1.load), 8'b0001);
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        chk("t32_out_en", 8'(b1.out_en), 8'hF);
        chk("t32_load", 8'(b1.load), 8'h0);
        chk("t32_busy", 8'(b1.busy), 8'h0);
        chk("t32_rd_data", 8'(b1.rd_data), 8'h0);
        chk("t32_done", 8'(b1.done), 8'h0);
        step();
        chk("t32_no_done", 8'(b1.done), 8'h0);
        chk("t32_idle", 8'(b1.busy), 8'h0);

        // reset wins over req at the same edge
        rst1 = 1'b1; b1.req = 1'b1;
        step();
        rst1 = 1'b0; b1.req = 1'b0;
        chk("t28_busy_a", 8'(b1.busy), 8'h0);
        step();
        chk("t28_busy_b", 8'(b1.busy), 8'h0);

        // SETTLE=3 instance
        b3.src = 2'd1; b3.dst = 2'd2; b3.wr = 1'b1; b3.bus_in = 4'hE; b3.req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            b3.req = 1'b0;
            chk("t31_drive_busy", 8'(b3.busy), 8'h1);
            chk("t31_drive_out_en", 8'(b3.out_en), 8'b1101);
            chk("t31_drive_load", 8'(b3.load), 8'h0);
            chk("t31_drive_done", 8'(b3.done), 8'h0);
        end
        step();
        chk("t31_c4_out_en", 8'(b3.out_en), 8'b1101);
        chk("t31_c4_load", 8'(b3.load), 8'b0100);
        step();
        chk("t31_c5_out_en", 8'(b3.out_en), 8'b1101);
        chk("t31_c5_done", 8'(b3.done), 8'h1);
        chk("t31_c5_rd_data", 8'(b3.rd_data), 8'hE);
        step();
        chk("t31_c6_busy", 8'(b3.busy), 8'h0);
        chk("t31_c6_out_en", 8'(b3.out_en), 8'hF);

        mon_en = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nibble_bus_ctrl.md
NIBBLE_BUS_CTRL -- requirements
Module: nibble_bus_ctrl

Interface
REQ-001 SHALL have parameter SETTLE, default 1, range 1..15: bus settle cycles between enabling a source register and sampling the bus.
REQ-002 SHALL have port clk, input, 1 bit: single clock for all state; every flop updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 1 bit: transfer request, sampled only in IDLE.
REQ-005 SHALL have port src, input, 2 bits: index of the source register that drives the bus.
REQ-006 SHALL have port dst, input, 2 bits: index of the destination register that is loaded.
REQ-007 SHALL have port wr, input, 1 bit: 1 = read and load dst; 0 = read only.
REQ-008 SHALL have port bus_in, input, 4 bits: shared nibble bus as seen by the controller.
REQ-009 SHALL have port out_en, output, 4 bits: per-register output enable, active-low; 0 = register drives the bus.
REQ-010 SHALL have port load, output, 4 bits: per-register load strobe, active-high; the register captures on the rising edge.
REQ-011 SHALL have port rd_data, output, 4 bits: last nibble sampled from the bus.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse marking the end of a transfer.

Function
REQ-014 SHALL implement a Moore FSM with four states: IDLE, DRIVE, STROBE, HOLD; out_en, load, busy and done SHALL decode from registered state only.
REQ-015 SHALL, in IDLE with req=1, latch src, dst and wr and go to DRIVE; it SHALL remain in IDLE while req=0.
REQ-016 SHALL, in DRIVE, drive out_en[src_q]=0 and all other out_en bits to 1; it SHALL hold DRIVE for exactly SETTLE cycles, counted by a settle counter, then go to STROBE.
REQ-017 SHALL, in STROBE, keep out_en[src_q]=0, drive load[dst_q]=wr_q, and capture bus_in into rd_data at the end of the cycle; next state is HOLD.
REQ-018 SHALL, in HOLD, drive load=4'b0000, keep out_en[src_q]=0 (data hold after the load edge), and assert done=1; next state is IDLE.
REQ-019 SHALL, in IDLE, drive out_en=4'b1111, load=4'b0000 and done=0.
REQ-020 SHALL give a latency, with req high in cycle 0, of: busy=1 from cycle 1; done=1 in cycle SETTLE+2; IDLE in cycle SETTLE+3.
REQ-021 SHALL accept req only in IDLE; req while busy is ignored and not queued, and input changes while busy have no effect.
REQ-022 SHALL accept a new req sampled in the done cycle: HOLD goes to IDLE regardless, and the first req accepted is one sampled in IDLE (one IDLE cycle minimum between transfers).
REQ-023 SHALL never drive more than one out_en bit low in any cycle.
REQ-024 SHALL never drive more than one load bit high, and SHALL drive load high only while an out_en bit is low.
REQ-025 SHALL permit src==dst with wr=1; the register is reloaded with its own value and the sequence is unchanged.
REQ-026 SHALL, when wr=0, keep load all zero for the whole transfer while still updating rd_data and pulsing done.

Reset
REQ-027 SHALL, when reset=1 at a rising edge in any state (including mid-transfer), enter IDLE with out_en=4'b1111, load=4'b0000, rd_data=4'h0, busy=0, done=0, and the settle counter and latched fields cleared.
REQ-028 SHALL give reset priority over req at the same edge; no transfer starts.

Verification
REQ-029 SHALL be verified with SETTLE=1, req src=2, dst=0, wr=1, bus_in=4'hA: out_en=1011 in cycles 1-3, load=0001 in cycle 2 only, rd_data=A and done=1 in cycle 3, busy=0 in cycle 4.
REQ-030 SHALL be verified with wr=0, src=3, bus_in=4'h5: load stays 0000 throughout, rd_data=5, done pulses once.
REQ-031 SHALL be verified with SETTLE=3: DRIVE lasts 3 cycles, done in cycle 5, and out_en is stable throughout.
REQ-032 SHALL be verified with reset asserted during STROBE: next cycle out_en=1111, load=0000, busy=0, rd_data=0, and no done pulse.
REQ-033 SHALL be verified with req held high continuously: back-to-back transfers separated by exactly one IDLE cycle, and a src/dst change mid-transfer ignored.
REQ-034 SHALL be verified with src==dst=1, wr=1, bus_in=4'h7: out_en=1101 and load=0010 in the STROBE cycle, rd_data=7.
